bounding_box: RTL and testbench

BOUNDING_BOX -- requirements
Module: bounding_box

---
 rtl/bounding_box_pkg.sv | 34 +++
 rtl/raster_counter.sv | 85 ++++++++
 rtl/bounding_box.sv | 142 ++++++++++++++
 tb/tb_bounding_box.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bounding_box_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bounding_box_pkg
// Description : Shared image-processing definitions for the bounding-box
//               block: coordinate width, FSM state encoding, accumulator
//               initial values and small min/max helpers.
// Revision    : 1.0  initial release
// ============================================================================
package bounding_box_pkg;

  localparam int COORD_W = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [0:0] {
    ST_SCAN   = 1'b0,
    ST_REPORT = 1'b1
  } state_e;

  // Accumulator start values: min trackers start high, max trackers low,
  // so the first object pixel always replaces both.
  localparam coord_t MIN_INIT = {COORD_W{1'b1}};
  localparam coord_t MAX_INIT = {COORD_W{1'b0}};

  function automatic coord_t coord_min(input coord_t a, input coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t coord_max(input coord_t a, input coord_t b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : raster_counter
// Description : Raster-order x/y position counter. Latches the frame size on
//               the first pixel of each frame and flags the end-of-frame pixel.
// Ports       : clock, reset_n     - clock, async active-low reset
//               img_width_i/_height_i - frame size, sampled at pixel (0,0)
//               in_valid_i         - advances the position by one pixel
//               x_o, y_o           - position of the pixel on in_valid_i
//               eof_o              - current accepted pixel is the last one
// Revision    : 1.0  initial release
// ============================================================================
module raster_counter
  import bounding_box_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] img_width_i,
  input  logic [COORD_W-1:0] img_height_i,
  input  logic               in_valid_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               eof_o
);

  coord_t x_q, x_d;
  coord_t y_q, y_d;
  coord_t width_q, width_d;
  coord_t height_q, height_d;

  logic   first;
  coord_t w_eff;
  coord_t h_eff;
  logic   x_last;
  logic   y_last;

  always_comb begin
    first    = (x_q == '0) && (y_q == '0);
    // On the first pixel the latched size is not yet valid, so the live
    // inputs are used directly; this lets a 1-pixel-wide/high frame end on
    // its very first pixel.
    w_eff    = first ? img_width_i  : width_q;
    h_eff    = first ? img_height_i : height_q;
    x_last   = (x_q == (w_eff - 16'd1));
    y_last   = (y_q == (h_eff - 16'd1));

    x_d      = x_q;
    y_d      = y_q;
    width_d  = width_q;
    height_d = height_q;

    if (in_valid_i) begin
      if (first) begin
        width_d  = img_width_i;
        height_d = img_height_i;
      end
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : (y_q + 16'd1);
      end else begin
        x_d = x_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= '0;
      y_q      <= '0;
      width_q  <= '0;
      height_q <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      width_q  <= width_d;
      height_q <= height_d;
    end
  end

  assign x_o   = x_q;
  assign y_o   = y_q;
  assign eof_o = in_valid_i & x_last & y_last;

endmodule
`default_nettype wire

// File: rtl/bounding_box.sv
`default_nettype none
// ============================================================================
// Module      : bounding_box
// Description : Computes the inclusive bounding box and pixel count of the
//               object pixels of each binary frame streamed in raster order,
//               reporting once per frame one cycle after its last pixel.
// Ports       : clock, reset_n         - clock, async active-low reset
//               img_width, img_height  - frame size (latched per frame)
//               in_valid, in_pixel     - pixel stream, 1 = object
//               out_valid              - one-cycle report strobe
//               out_empty              - reported frame had no object pixel
//               out_xmin/xmax/ymin/ymax- inclusive bounding box
//               out_count              - object pixel count (saturating)
// Revision    : 1.0  initial release
// ============================================================================
module bounding_box
  import bounding_box_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] img_width,
  input  logic [COORD_W-1:0] img_height,
  input  logic               in_valid,
  input  logic               in_pixel,
  output logic               out_valid,
  output logic               out_empty,
  output logic [COORD_W-1:0] out_xmin,
  output logic [COORD_W-1:0] out_xmax,
  output logic [COORD_W-1:0] out_ymin,
  output logic [COORD_W-1:0] out_ymax,
  output logic [COUNT_W-1:0] out_count
);

  coord_t x;
  coord_t y;
  logic   eof;

  raster_counter u_raster_counter (
    .clock        (clock),
    .reset_n      (reset_n),
    .img_width_i  (img_width),
    .img_height_i (img_height),
    .in_valid_i   (in_valid),
    .x_o          (x),
    .y_o          (y),
    .eof_o        (eof)
  );

  state_e             state_q;

  coord_t             xmin_q, xmin_d;
  coord_t             xmax_q, xmax_d;
  coord_t             ymin_q, ymin_d;
  coord_t             ymax_q, ymax_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               found_q, found_d;

  logic               out_empty_q;
  coord_t             out_xmin_q, out_xmax_q, out_ymin_q, out_ymax_q;
  logic [COUNT_W-1:0] out_count_q;

  logic               hit;

  // Accumulators with the current pixel merged in. These are what get
  // reported on the EOF pixel, so the last pixel is always included.
  always_comb begin
    hit     = in_valid & in_pixel;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    count_d = count_q;
    found_d = found_q;
    if (hit) begin
      xmin_d  = coord_min(xmin_q, x);
      xmax_d  = coord_max(xmax_q, x);
      ymin_d  = coord_min(ymin_q, y);
      ymax_d  = coord_max(ymax_q, y);
      found_d = 1'b1;
      // Saturate rather than wrap when COUNT_W is narrower than the frame.
      if (count_q != {COUNT_W{1'b1}}) begin
        count_d = count_q + COUNT_W'(1);
      end
    end
  end

  // The REPORT cycle also accepts pixels: accumulators were reinitialised on
  // entry, so the pixel there simply becomes (0,0) of the next frame. An EOF
  // pixel accepted during REPORT (1x1 frames) re-enters REPORT so that every
  // frame still gets its own report.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SCAN;
      xmin_q      <= MIN_INIT;
      xmax_q      <= MAX_INIT;
      ymin_q      <= MIN_INIT;
      ymax_q      <= MAX_INIT;
      count_q     <= '0;
      found_q     <= 1'b0;
      out_empty_q <= 1'b1;
      out_xmin_q  <= '0;
      out_xmax_q  <= '0;
      out_ymin_q  <= '0;
      out_ymax_q  <= '0;
      out_count_q <= '0;
    end else if (eof) begin
      state_q     <= ST_REPORT;
      out_empty_q <= ~found_d;
      out_xmin_q  <= found_d ? xmin_d : '0;
      out_xmax_q  <= found_d ? xmax_d : '0;
      out_ymin_q  <= found_d ? ymin_d : '0;
      out_ymax_q  <= found_d ? ymax_d : '0;
      out_count_q <= count_d;
      xmin_q      <= MIN_INIT;
      xmax_q      <= MAX_INIT;
      ymin_q      <= MIN_INIT;
      ymax_q      <= MAX_INIT;
      count_q     <= '0;
      found_q     <= 1'b0;
    end else begin
      state_q     <= ST_SCAN;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      count_q     <= count_d;
      found_q     <= found_d;
    end
  end

  assign out_valid = (state_q == ST_REPORT);
  assign out_empty = out_empty_q;
  assign out_xmin  = out_xmin_q;
  assign out_xmax  = out_xmax_q;
  assign out_ymin  = out_ymin_q;
  assign out_ymax  = out_ymax_q;
  assign out_count = out_count_q;

endmodule
`default_nettype wire

// File: tb/tb_bounding_box.sv
`default_nettype none
// ============================================================================
// Module      : tb_bounding_box
// Description : Self-checking bench for bounding_box. Frames are built as
//               whole images; the expected result of each frame is derived
//               from the image by plain loops and compared every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bounding_box;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] img_width, img_height;
  logic        in_valid, in_pixel;
  logic        out_valid, out_empty;
  logic [15:0] out_xmin, out_xmax, out_ymin, out_ymax;
  logic [31:0] out_count;

  bounding_box #(.COUNT_W(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .img_width  (img_width),
    .img_height (img_height),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_empty  (out_empty),
    .out_xmin   (out_xmin),
    .out_xmax   (out_xmax),
    .out_ymin   (out_ymin),
    .out_ymax   (out_ymax),
    .out_count  (out_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    bit          empty;
    logic [15:0] xmin, xmax, ymin, ymax;
    logic [31:0] count;
  } res_t;

  res_t expq[$];
  res_t last;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   img[0:255];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic res_t mk(bit e, int xa, int xb, int ya, int yb, int c);
    res_t r;
    r.cyc = 0; r.empty = e;
    r.xmin = 16'(xa); r.xmax = 16'(xb); r.ymin = 16'(ya); r.ymax = 16'(yb);
    r.count = 32'(c);
    return r;
  endfunction

  function automatic res_t snap();
    return mk(out_empty, int'(out_xmin), int'(out_xmax), int'(out_ymin),
              int'(out_ymax), int'(out_count));
  endfunction

  // Reference: scan the whole image, take min/max of set coordinates.
  function automatic res_t model(int w, int h, int at);
    res_t r;
    int xa = 65535, xb = 0, ya = 65535, yb = 0, c = 0;
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++)
        if (img[yy*w+xx]) begin
          c++;
          if (xx < xa) xa = xx;
          if (xx > xb) xb = xx;
          if (yy < ya) ya = yy;
          if (yy > yb) yb = yy;
        end
    r = (c == 0) ? mk(1, 0, 0, 0, 0, 0) : mk(0, xa, xb, ya, yb, c);
    r.cyc = at;
    return r;
  endfunction

  task automatic check_eq(string name, bit vld_got, bit vld_exp, res_t got, res_t exp);
    checks++;
    if (vld_got !== vld_exp || got.empty !== exp.empty || got.xmin !== exp.xmin ||
        got.xmax !== exp.xmax || got.ymin !== exp.ymin || got.ymax !== exp.ymax ||
        got.count !== exp.count) begin
      errors++;
      $display("FAIL %s @cyc %0d: got v=%0b e=%0b box=(%0d,%0d,%0d,%0d) n=%0d, expected v=%0b e=%0b box=(%0d,%0d,%0d,%0d) n=%0d",
               name, cyc, vld_got, got.empty, got.xmin, got.xmax, got.ymin, got.ymax, got.count,
               vld_exp, exp.empty, exp.xmin, exp.xmax, exp.ymin, exp.ymax, exp.count);
    end
  endtask

  // Every-cycle compare: a report when one is due, otherwise held outputs.
  always @(negedge clock) begin
    if (expq.size() > 0 && expq[0].cyc == cyc) begin
      check_eq("report", out_valid, 1'b1, snap(), expq[0]);
      last = expq[0];
      void'(expq.pop_front());
    end else begin
      check_eq("hold", out_valid, 1'b0, snap(), last);
    end
  end

  task automatic put(bit v, bit p);
    in_valid = v;
    in_pixel = p;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) put(1'b0, 1'b0);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 1'b0;
  endtask

  // Stream one frame from img[]. gaps inserts random idle cycles, garb
  // scrambles the size inputs after pixel 0, neww (if non-zero) replaces the
  // width after pixel 0, abort_n (if non-zero) stops after that many pixels.
  task automatic run_frame(int w, int h, bit gaps, bit garb, int neww, int abort_n);
    img_width  = 16'(w);
    img_height = 16'(h);
    for (int i = 0; i < w*h; i++) begin
      if (abort_n != 0 && i == abort_n) return;
      if (gaps) repeat ($urandom_range(0, 2)) put(1'b0, 1'($urandom_range(0, 1)));
      if (i == w*h-1) expq.push_back(model(w, h, cyc + 1));
      put(1'b1, img[i]);
      if (i == 0 && garb) begin
        img_width  = 16'($urandom_range(1, 20));
        img_height = 16'($urandom_range(1, 20));
      end
      if (i == 0 && neww != 0) img_width = 16'(neww);
    end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_pixel = 1'b0;
    expq.delete();
    last = mk(1, 0, 0, 0, 0, 0);
    #1;
    check_eq("reset_async", out_valid, 1'b0, snap(), mk(1, 0, 0, 0, 0, 0));
    put(1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    res_t r;
    int w, h, dens;
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_pixel   = 1'b0;
    img_width  = 16'd4;
    img_height = 16'd3;
    last       = mk(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    check_eq("reset_state", out_valid, 1'b0, snap(), mk(1, 0, 0, 0, 0, 0));
    reset_n = 1'b1;
    idle(2);

    // Single pixel at (2,1) in a 4x3 frame.
    clear_img(); img[1*4+2] = 1'b1;
    r = model(4, 3, 0);
    check_eq("pin_single", 1'b0, 1'b0, r, mk(0, 2, 2, 1, 1, 1));
    run_frame(4, 3, 0, 0, 0, 0);
    idle(3);
    check_eq("dut_single", 1'b0, out_valid, snap(), mk(0, 2, 2, 1, 1, 1));

    // All-zero frame.
    clear_img();
    run_frame(4, 3, 0, 0, 0, 0);
    idle(3);
    check_eq("dut_empty", 1'b0, out_valid, snap(), mk(1, 0, 0, 0, 0, 0));

    // 8x4 with gaps, pixels (1,0),(6,3),(3,2).
    clear_img(); img[0*8+1] = 1'b1; img[3*8+6] = 1'b1; img[2*8+3] = 1'b1;
    r = model(8, 4, 0);
    check_eq("pin_8x4", 1'b0, 1'b0, r, mk(0, 1, 6, 0, 3, 3));
    run_frame(8, 4, 1, 0, 0, 0);
    idle(3);
    check_eq("dut_8x4", 1'b0, out_valid, snap(), mk(0, 1, 6, 0, 3, 3));

    // Back-to-back: frame 1 ends on its set EOF pixel, frame 2's set (0,0)
    // pixel lands in the REPORT cycle.
    clear_img(); img[11] = 1'b1;
    check_eq("pin_eof", 1'b0, 1'b0, model(4, 3, 0), mk(0, 3, 3, 2, 2, 1));
    run_frame(4, 3, 0, 0, 0, 0);
    clear_img(); img[0] = 1'b1;
    run_frame(4, 3, 0, 0, 0, 0);
    idle(3);
    check_eq("dut_b2b", 1'b0, out_valid, snap(), mk(0, 0, 0, 0, 0, 1));

    // Reset after 5 pixels of a frame with a set pixel, then a clean frame.
    clear_img(); img[1] = 1'b1;
    run_frame(4, 3, 0, 0, 0, 5);
    do_reset();
    clear_img(); img[2*4+2] = 1'b1;
    run_frame(4, 3, 0, 0, 0, 0);
    idle(3);
    check_eq("dut_after_rst", 1'b0, out_valid, snap(), mk(0, 2, 2, 2, 2, 1));

    // Width changed 4->8 mid-frame; next frame 8x2.
    clear_img(); img[11] = 1'b1;
    run_frame(4, 3, 0, 0, 8, 0);
    clear_img(); img[1*8+7] = 1'b1; img[0*8+5] = 1'b1;
    run_frame(8, 2, 0, 0, 0, 0);
    idle(3);
    check_eq("dut_newwidth", 1'b0, out_valid, snap(), mk(0, 5, 7, 0, 1, 2));

    // Randomised frames.
    for (int f = 0; f < 40; f++) begin
      w = $urandom_range(1, 12);
      h = $urandom_range(1, 6);
      case ($urandom_range(0, 3))
        0: dens = 0;
        1: dens = 10;
        2: dens = 50;
        default: dens = 100;
      endcase
      for (int i = 0; i < w*h; i++) img[i] = ($urandom_range(0, 99) < dens);
      run_frame(w, h, ($urandom_range(0, 1) == 1) || (w*h == 1),
                1'($urandom_range(0, 1)), 0, 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(4);

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL pending_reports: got %0d outstanding, expected 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
